// File: rtl/otter_dmem_load_responder.sv
// Load-port responder for the OTTER data SRAM: one outstanding load, programmable pre-access wait,
// lane extraction and sign/zero extension. Optional misalignment trap: OTTER_DMEM_MISALIGN_CHK_EN.
module otter_dmem_load_responder #(
    parameter int SRAM_AW = 14,
    parameter int LATENCY = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [31:0]        MEM_ADDR2,
    input  logic               MEM_READ,
    input  logic [1:0]         MEM_SIZE,
    input  logic               MEM_SIGN,
    output logic               sram_en,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [31:0]        sram_rdata,
    output logic               mem_resp,
    output logic               mem_resp_valid,
    output logic [31:0]        mem_data_in,
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DATA  = 3'd3,
        ST_RESP  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic [31:0]         addr_r;
    logic [1:0]          size_r;
    logic                sign_r;
    logic                capture_s;
    logic                fault_s;
    logic                misalign_s;
    logic [SRAM_AW-1:0]  issue_addr_s;

    logic                sram_en_r;
    logic [SRAM_AW-1:0]  sram_addr_r;
    logic                mem_resp_r;
    logic                mem_resp_valid_r;
    logic [31:0]         mem_data_in_r;
    logic                busy_r;

    // Byte/half lane select plus extension; sizes 2 and 3 both return the whole word.
    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    res = zext ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    res = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef OTTER_DMEM_MISALIGN_CHK_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    // Misalignment qualifier for the request currently presented in IDLE.
    always_comb begin
`ifdef OTTER_DMEM_MISALIGN_CHK_EN
        misalign_s = is_misaligned(MEM_SIZE, MEM_ADDR2[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // Next-state and counter logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        fault_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MEM_READ) begin
                    capture_s = 1'b1;
                    if (misalign_s) begin
                        fault_s = 1'b1;
                        state_s = ST_RESP;
                    end else if (LATENCY > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = LAT_M1;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ISSUE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ISSUE: state_s = ST_DATA;
            ST_DATA:  state_s = ST_RESP;
            ST_RESP:  state_s = ST_HOLD;
            ST_HOLD: begin
                // Leave only once the requester has dropped or replaced the served request.
                if (!MEM_READ || ({MEM_ADDR2, MEM_SIZE, MEM_SIGN} != {addr_r, size_r, sign_r})) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // With zero latency the capture and the issue happen on the same edge.
    always_comb begin
        if (capture_s) begin
            issue_addr_s = MEM_ADDR2[SRAM_AW+1:2];
        end else begin
            issue_addr_s = addr_r[SRAM_AW+1:2];
        end
    end

    // State, counter and captured request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'h0000_0000;
            size_r  <= 2'd0;
            sign_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (capture_s) begin
                addr_r <= MEM_ADDR2;
                size_r <= MEM_SIZE;
                sign_r <= MEM_SIGN;
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sram_en_r        <= 1'b0;
            sram_addr_r      <= '0;
            mem_resp_r       <= 1'b0;
            mem_resp_valid_r <= 1'b0;
            mem_data_in_r    <= 32'h0000_0000;
            busy_r           <= 1'b0;
        end else begin
            sram_en_r        <= (state_s == ST_ISSUE);
            mem_resp_r       <= (state_s == ST_RESP);
            mem_resp_valid_r <= (state_s == ST_RESP) && !fault_s;
            busy_r           <= (state_s != ST_IDLE);
            if (state_s == ST_ISSUE) begin
                sram_addr_r <= issue_addr_s;
            end
            if (state_r == ST_DATA) begin
                mem_data_in_r <= fmt_load(sram_rdata, addr_r[1:0], size_r, sign_r);
            end else if (fault_s) begin
                mem_data_in_r <= 32'h0000_0000;
            end
        end
    end

    assign sram_en        = sram_en_r;
    assign sram_addr      = sram_addr_r;
    assign mem_resp       = mem_resp_r;
    assign mem_resp_valid = mem_resp_valid_r;
    assign mem_data_in    = mem_data_in_r;
    assign busy           = busy_r;

endmodule
